// File: rtl/vscale_htif_pkg.sv
// Shared definitions for the HTIF tohost monitor: FSM encoding, CSR address and PCR constants.
package vscale_htif_pkg;

  localparam logic [11:0] CSR_ADDR_TO_HOST    = 12'h780;
  localparam logic [11:0] TOHOST_ADDR_DEFAULT = CSR_ADDR_TO_HOST;
  localparam int unsigned HTIF_PCR_WIDTH      = 64;
  localparam int unsigned PASS_VALUE          = 1;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdResp,
    StWrReq,
    StWrResp,
    StDone
  } state_e;

  // Hart index width; never narrower than one bit so a single hart still has a port.
  function automatic int unsigned hart_width(int unsigned num_harts);
    return (num_harts > 1) ? $clog2(num_harts) : 1;
  endfunction

endpackage

// File: rtl/vscale_htif_tohost_monitor_if.sv
// HTIF PCR request/response channel; the monitor is the master, the core side the slave.
interface vscale_htif_tohost_monitor_if
  import vscale_htif_pkg::*;
#(
  parameter int unsigned PCR_WIDTH  = HTIF_PCR_WIDTH,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned HW         = 1
);

  logic                  htif_pcr_req_valid;
  logic                  htif_pcr_req_ready;
  logic                  htif_pcr_req_rw;
  logic [ADDR_WIDTH-1:0] htif_pcr_req_addr;
  logic [PCR_WIDTH-1:0]  htif_pcr_req_data;
  logic [HW-1:0]         htif_pcr_req_hart;
  logic                  htif_pcr_resp_valid;
  logic                  htif_pcr_resp_ready;
  logic [PCR_WIDTH-1:0]  htif_pcr_resp_data;

  modport master (
    output htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    output htif_pcr_req_hart, htif_pcr_resp_ready,
    input  htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
  );

  modport slave (
    input  htif_pcr_req_valid, htif_pcr_req_rw, htif_pcr_req_addr, htif_pcr_req_data,
    input  htif_pcr_req_hart, htif_pcr_resp_ready,
    output htif_pcr_req_ready, htif_pcr_resp_valid, htif_pcr_resp_data
  );

endinterface

// File: rtl/vscale_rr_next_hart.sv
// Picks the next hart after cur_hart (modulo NUM_HARTS) whose pass flag is still clear.
module vscale_rr_next_hart #(
  parameter int unsigned NUM_HARTS = 1,
  parameter int unsigned HW        = 1
) (
  input  logic [HW-1:0]        cur_hart,
  input  logic [NUM_HARTS-1:0] hart_passed,
  output logic [HW-1:0]        next_hart
);

  if (NUM_HARTS == 1) begin : gen_single
    logic unused;
    assign unused    = ^{cur_hart, hart_passed};
    assign next_hart = '0;
  end else begin : gen_multi
    logic [HW-1:0] cand;
    // Scan farthest offset first so the nearest unpassed hart is the last one written.
    always_comb begin
      cand      = '0;
      next_hart = cur_hart;
      for (int k = int'(NUM_HARTS); k >= 1; k--) begin
        cand = HW'((int'(cur_hart) + k) % int'(NUM_HARTS));
        if (!hart_passed[cand]) next_hart = cand;
      end
    end
  end

endmodule

// File: rtl/vscale_htif_tohost_monitor.sv
// Polls tohost on each hart over HTIF, clears non-zero values, reports pass/fail/timeout.
module vscale_htif_tohost_monitor
  import vscale_htif_pkg::*;
#(
  parameter int unsigned NUM_HARTS                = 1,
  parameter int unsigned PCR_WIDTH                = HTIF_PCR_WIDTH,
  parameter int unsigned ADDR_WIDTH               = 12,
  parameter logic [ADDR_WIDTH-1:0] TOHOST_ADDR    = ADDR_WIDTH'(TOHOST_ADDR_DEFAULT),
  parameter int unsigned CYCLE_WIDTH              = 64,
  localparam int unsigned HW                      = hart_width(NUM_HARTS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYCLE_WIDTH-1:0] max_cycles,
  vscale_htif_tohost_monitor_if.master htif,
  output logic                   done,
  output logic                   pass,
  output logic                   timeout,
  output logic [PCR_WIDTH-1:0]   fail_code,
  output logic [HW-1:0]          fail_hart,
  output logic [CYCLE_WIDTH-1:0] cycle_count,
  output logic [NUM_HARTS-1:0]   hart_passed
);

  state_e                 state_q, state_d;
  logic [HW-1:0]          cur_hart_q, cur_hart_d, next_hart;
  logic [NUM_HARTS-1:0]   hart_passed_q, hart_passed_d;
  logic                   fail_q, fail_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [PCR_WIDTH-1:0]   fail_code_q, fail_code_d;
  logic [HW-1:0]          fail_hart_q, fail_hart_d;
  logic [CYCLE_WIDTH-1:0] cycle_q, cycle_d;
  logic                   active;

  vscale_rr_next_hart #(
    .NUM_HARTS(NUM_HARTS),
    .HW       (HW)
  ) u_next_hart (
    .cur_hart   (cur_hart_q),
    .hart_passed(hart_passed_q),
    .next_hart  (next_hart)
  );

  assign active = (state_q == StRdReq) || (state_q == StRdResp) ||
                  (state_q == StWrReq) || (state_q == StWrResp);

  always_comb begin
    state_d       = state_q;
    cur_hart_d    = cur_hart_q;
    hart_passed_d = hart_passed_q;
    fail_d        = fail_q;
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    fail_code_d   = fail_code_q;
    fail_hart_d   = fail_hart_q;
    cycle_d       = cycle_q;
    if (active && (max_cycles != '0) && (cycle_q >= max_cycles)) begin
      // Timeout wins over any handshake completing in the same cycle.
      state_d   = StDone;
      timeout_d = 1'b1;
    end else begin
      if (active && (cycle_q != {CYCLE_WIDTH{1'b1}})) cycle_d = cycle_q + 1'b1;
      unique case (state_q)
        StIdle:  if (start) state_d = StRdReq;
        StRdReq: if (htif.htif_pcr_req_ready) state_d = StRdResp;
        StRdResp: begin
          if (htif.htif_pcr_resp_valid) begin
            if (htif.htif_pcr_resp_data == '0) begin
              cur_hart_d = next_hart;
              state_d    = StRdReq;
            end else if (htif.htif_pcr_resp_data == PCR_WIDTH'(PASS_VALUE)) begin
              hart_passed_d[cur_hart_q] = 1'b1;
              state_d                   = StWrReq;
            end else begin
              fail_code_d = htif.htif_pcr_resp_data >> 1;
              fail_hart_d = cur_hart_q;
              fail_d      = 1'b1;
              state_d     = StWrReq;
            end
          end
        end
        StWrReq: if (htif.htif_pcr_req_ready) state_d = StWrResp;
        StWrResp: begin
          if (htif.htif_pcr_resp_valid) begin
            if (fail_q) begin
              state_d = StDone;
            end else if (&hart_passed_q) begin
              pass_d  = 1'b1;
              state_d = StDone;
            end else begin
              cur_hart_d = next_hart;
              state_d    = StRdReq;
            end
          end
        end
        StDone:  state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      cur_hart_q    <= '0;
      hart_passed_q <= '0;
      fail_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      fail_code_q   <= '0;
      fail_hart_q   <= '0;
      cycle_q       <= '0;
    end else begin
      state_q       <= state_d;
      cur_hart_q    <= cur_hart_d;
      hart_passed_q <= hart_passed_d;
      fail_q        <= fail_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      fail_code_q   <= fail_code_d;
      fail_hart_q   <= fail_hart_d;
      cycle_q       <= cycle_d;
    end
  end

  assign htif.htif_pcr_req_valid  = (state_q == StRdReq) || (state_q == StWrReq);
  assign htif.htif_pcr_req_rw     = (state_q == StWrReq);
  assign htif.htif_pcr_req_addr   = TOHOST_ADDR;
  assign htif.htif_pcr_req_data   = '0;
  assign htif.htif_pcr_req_hart   = cur_hart_q;
  assign htif.htif_pcr_resp_ready = (state_q == StRdResp) || (state_q == StWrResp);

  assign done        = (state_q == StDone);
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign fail_code   = fail_code_q;
  assign fail_hart   = fail_hart_q;
  assign cycle_count = cycle_q;
  assign hart_passed = hart_passed_q;

endmodule

// File: doc/vscale_htif_tohost_monitor.md
Name: vscale_htif_tohost_monitor

Overview:
- Synthesizable multi-hart successor to the simulation-only tohost poller; suitable for FPGA and emulation.
- Polls the tohost CSR of NUM_HARTS harts round-robin over the HTIF PCR request/response channel.
- Clears each non-zero tohost value with a write of 0.
- Reports pass, fail (code and hart) or cycle timeout as registered status outputs.
- Sits between the vscale_sim_top HTIF ports and a board-level status register or LEDs.

Parameters:
- NUM_HARTS, 1, harts polled; hart index width HW = max(1, clog2(NUM_HARTS)).
- PCR_WIDTH, 64, HTIF PCR data width.
- ADDR_WIDTH, 12, CSR address width.
- TOHOST_ADDR, 12'h780, CSR address of tohost.
- CYCLE_WIDTH, 64, width of cycle counter and limit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- start  in  1  level; begin polling when high in IDLE
- max_cycles  in  CYCLE_WIDTH  timeout limit; 0 disables timeout
- htif_pcr_req_valid  out  1  request valid
- htif_pcr_req_ready  in  1  request accepted
- htif_pcr_req_rw  out  1  0 = read, 1 = write
- htif_pcr_req_addr  out  ADDR_WIDTH  always TOHOST_ADDR
- htif_pcr_req_data  out  PCR_WIDTH  always 0
- htif_pcr_req_hart  out  HW  target hart
- htif_pcr_resp_valid  in  1  response valid
- htif_pcr_resp_ready  out  1  response accept
- htif_pcr_resp_data  in  PCR_WIDTH  response data
- done  out  1  sticky; test finished
- pass  out  1  all harts wrote 1
- timeout  out  1  cycle limit reached
- fail_code  out  PCR_WIDTH  failing tohost >> 1
- fail_hart  out  HW  hart that failed
- cycle_count  out  CYCLE_WIDTH  cycles spent polling
- hart_passed  out  NUM_HARTS  per-hart pass flags

Behaviour:
- Reset (reset == 0 at posedge clk) → state IDLE; all outputs 0 except htif_pcr_req_addr = TOHOST_ADDR; cur_hart = 0. Reset mid-transaction abandons the transaction with no recovery write.
- All outputs are registered or derived only from state; no combinational path from any input to an output.
- FSM states: IDLE, RD_REQ, RD_RESP, WR_REQ, WR_RESP, DONE.
- IDLE: start = 1 → RD_REQ.
- RD_REQ: req_valid = 1, rw = 0, hart = cur_hart. Valid and payload are held stable until req_ready; on req_ready → RD_RESP.
- RD_RESP: resp_ready = 1. On resp_valid:
  - data == 0 → advance, then RD_REQ.
  - data == 1 → set hart_passed[cur_hart], go to WR_REQ.
  - otherwise → latch fail_code = data >> 1, fail_hart = cur_hart, set fail flag, go to WR_REQ.
- WR_REQ: req_valid = 1, rw = 1, data = 0; on req_ready → WR_RESP.
- WR_RESP: resp_ready = 1. On resp_valid:
  - fail flag set → DONE.
  - all hart_passed set → DONE with pass = 1.
  - otherwise → advance, then RD_REQ.
- Advance: cur_hart moves to the next index modulo NUM_HARTS whose hart_passed bit is 0. NUM_HARTS = 1 always selects 0.
- Timing: minimum 2 cycles per read poll with ready and valid both high at first opportunity; req_valid is low in the response states.
- cycle_count increments by 1 every cycle in RD_REQ through WR_RESP. It saturates at all-ones and never wraps.
- Timeout: max_cycles != 0 and cycle_count >= max_cycles → DONE with timeout = 1. Timeout has priority over a same-cycle response; req_valid drops even if the request is unaccepted.
- DONE: done = 1; req_valid = 0, resp_ready = 0; status frozen until reset. start is ignored.
- Stray resp_valid in IDLE, RD_REQ, WR_REQ or DONE is ignored.

Decomposition:
- Package vscale_htif_pkg holds:
  - FSM state encoding.
  - TOHOST_ADDR default (shared with CSR_ADDR_TO_HOST).
  - PASS_VALUE = 1 and HTIF_PCR_WIDTH.
- Sub-module vscale_rr_next_hart: combinational next-unpassed-hart selector, parameterised by NUM_HARTS.

Test Plan:
- NUM_HARTS = 1; model returns 0 three times then 1 → one write of 0 follows; done = 1, pass = 1, timeout = 0, hart_passed = 1.
- Model returns 7 → write of 0 issued; done = 1, pass = 0, fail_code = 3, fail_hart = 0.
- max_cycles = 50; tohost always 0 → done = 1, timeout = 1, cycle_count = 50, req_valid low in the following cycle.
- NUM_HARTS = 4:
  - Harts 0, 1 and 3 return 1; they are skipped in later polls (hart order verified).
  - Hart 2 then returns 5 → fail_hart = 2, fail_code = 2, hart_passed = 4'b1011.
- req_ready held low 10 cycles → req_valid, rw, hart and addr stay stable for all 10 cycles; single transaction accepted.
- reset asserted during WR_REQ → next cycle: IDLE, all status 0, req_valid = 0; re-run with start = 1 completes normally.
